ts_packet_sync: RTL and testbench
=================================

Name: ts_packet_sync

Overview:
- Receive-side sink for the MPEG-2 TS byte stream: the consumer of the byte/valid interface driven by the file stimulus and by upstream TS sources.
- Acquires and tracks 188-byte packet alignment from the 0x47 sync byte.
- Forwards aligned packets with start and end markers, and extracts the PID and TEI of each packet.
- Maintains packet and sync-loss statistics for the QoS monitoring logic.

Parameters:
- DATA_WIDTH, 8, stream byte width.
- PKT_LEN, 188, TS packet length in bytes.
- SYNC_BYTE, 8'h47, sync byte value.
- LOCK_COUNT, 3, consecutive correctly spaced sync bytes required to lock (≥2).
- UNLOCK_COUNT, 3, consecutive missing sync bytes that drop lock (≥1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data is valid this cycle; may be low for any number of cycles.
- in_data  in  DATA_WIDTH  TS stream byte.
- out_valid  out  1  forwarded byte valid.
- out_data  out  DATA_WIDTH  forwarded byte.
- out_sop  out  1  first byte of packet (sync position); qualified by out_valid.
- out_eop  out  1  byte PKT_LEN-1 of packet; qualified by out_valid.
- locked  out  1  block is in LOCKED state.
- pid  out  13  PID of the current packet.
- tei  out  1  transport_error_indicator of the current packet.
- pid_valid  out  1  one-cycle pulse: pid and tei were updated.
- pkt_count  out  CNT_WIDTH  packets forwarded with eop (saturating).
- sync_loss_count  out  CNT_WIDTH  LOCKED→HUNT transitions (saturating).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - all outputs 0; state HUNT; position, match and miss counters 0.
  - rst has priority over everything, including mid-packet; no partial packet resumes after reset.
- Only cycles with in_valid=1 advance state or position; idle cycles hold everything, and all out_* pulses are 0 on those cycles.
- pos: byte position 0..PKT_LEN-1; increments per valid byte, wraps PKT_LEN-1→0.
- HUNT:
  - valid byte == SYNC_BYTE → VERIFY, pos←1, match←1; otherwise stay.
- VERIFY:
  - non-sync positions: pos advances.
  - at pos==0: byte == SYNC_BYTE → match+1; when match+1 == LOCK_COUNT → LOCKED, and this byte is forwarded as out_sop.
  - at pos==0, byte ≠ SYNC_BYTE → HUNT. If that same byte... is not sync by definition, so hunting restarts from the next byte.
- LOCKED:
  - every valid byte is forwarded.
  - at pos==0 with byte == SYNC_BYTE → miss←0.
  - at pos==0 with byte ≠ SYNC_BYTE → miss+1.
    - If miss+1 < UNLOCK_COUNT: flywheel — byte is forwarded with out_sop=1.
    - If miss+1 == UNLOCK_COUNT: → HUNT, sync_loss_count+1, and this byte is NOT forwarded. locked falls on the same edge, so no orphan sop is emitted.
  - Lock is never dropped mid-packet.
- Output timing: one-cycle registered latency; out_* reflect the in_data accepted on the previous edge. locked rises on the edge where the locking sync byte's out_sop is registered.
- out_sop = forwarded byte at pos 0; out_eop = forwarded byte at pos PKT_LEN-1.
- PID/TEI extraction:
  - at forwarded pos 1: capture byte[7] as tei and byte[4:0] as pid[12:8].
  - at forwarded pos 2: pid[7:0] ← byte; pid_valid pulses in the same cycle as that byte's out_valid.
  - pid and tei hold until the next packet's update.
- pkt_count increments in the cycle out_eop is asserted.
- Both counters saturate at all-ones.

Test Plan:
- Clean stream, 5 packets, in_valid alternating 0/1 as the file stimulus drives it:
  - locked rises one cycle after byte offset 376 is accepted.
  - first out_sop carries 0x47; no output before that.
  - pkt_count = 3 after the final eop; sync_loss_count = 0.
- PID/TEI: packet bytes 0x47,0x41,0x00 → pid=0x100, tei=0; next packet 0x47,0xC0,0x11 → pid=0x011, tei=1. pid_valid pulses exactly once per packet, aligned with out pos 2.
- Single corrupted sync byte (0x00) while locked:
  - locked stays 1; that packet is still forwarded with out_sop=1.
  - sync_loss_count = 0; the next good sync clears miss.
- Three consecutive corrupted sync bytes:
  - locked falls at the third; that byte has no out_valid.
  - sync_loss_count = 1.
  - Relock requires 3 new good syncs (≥376 bytes).
- False sync in HUNT: 0x47 at offset 5, then random data with no 0x47 at offset 193 → returns to HUNT, locked stays 0. True alignment at offset 10 then locks.
- rst asserted mid-packet while locked (pos ≈ 90) → next cycle all outputs 0, state HUNT; counters cleared; relock behaves as in the first scenario.

Source files
------------

// File: rtl/ts_packet_sync.sv
// MPEG-2 TS receive-side packet synchroniser: acquires 188-byte alignment from the
// sync byte, forwards aligned packets with sop/eop, extracts PID/TEI, keeps statistics.
module ts_packet_sync #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PKT_LEN      = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'h47,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 3,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  locked,
    output logic [12:0]           pid,
    output logic                  tei,
    output logic                  pid_valid,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  sync_loss_count
);

    localparam int POS_W   = $clog2(PKT_LEN);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [POS_W-1:0]   pos, pos_nxt, pos_inc;
    logic [MATCH_W-1:0] match, match_nxt, match_inc;
    logic [MISS_W-1:0]  miss, miss_nxt, miss_inc;
    logic               is_sync;
    logic               fwd;
    logic               lost;
    logic               at_first, at_last;

    assign is_sync   = (in_data == SYNC_BYTE);
    assign at_first  = (pos == '0);
    assign at_last   = (pos == POS_W'(PKT_LEN - 1));
    assign pos_inc   = at_last ? '0 : pos + POS_W'(1);
    assign match_inc = match + MATCH_W'(1);
    assign miss_inc  = miss + MISS_W'(1);
    assign locked    = (state == ST_LOCKED);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        pos_nxt   = pos;
        match_nxt = match;
        miss_nxt  = miss;
        fwd       = 1'b0;
        lost      = 1'b0;
        if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    if (is_sync) begin
                        state_nxt = ST_VERIFY;
                        pos_nxt   = POS_W'(1);
                        match_nxt = MATCH_W'(1);
                    end
                end
                ST_VERIFY: begin
                    pos_nxt = pos_inc;
                    if (at_first) begin
                        if (is_sync) begin
                            match_nxt = match_inc;
                            if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                                state_nxt = ST_LOCKED;
                                miss_nxt  = '0;
                                fwd       = 1'b1;
                            end
                        end else begin
                            // The failing byte is not a sync, so hunting resumes on the next byte.
                            state_nxt = ST_HUNT;
                            pos_nxt   = '0;
                            match_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    pos_nxt = pos_inc;
                    fwd     = 1'b1;
                    if (at_first) begin
                        if (is_sync) begin
                            miss_nxt = '0;
                        end else if (miss_inc == MISS_W'(UNLOCK_COUNT)) begin
                            // Drop lock on the missing sync itself so no orphan sop leaves the block.
                            state_nxt = ST_HUNT;
                            pos_nxt   = '0;
                            match_nxt = '0;
                            miss_nxt  = '0;
                            fwd       = 1'b0;
                            lost      = 1'b1;
                        end else begin
                            miss_nxt = miss_inc;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    pos_nxt   = '0;
                    match_nxt = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_HUNT;
            pos             <= '0;
            match           <= '0;
            miss            <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            pid             <= '0;
            tei             <= 1'b0;
            pid_valid       <= 1'b0;
            pkt_count       <= '0;
            sync_loss_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state     <= state_nxt;
            pos       <= pos_nxt;
            match     <= match_nxt;
            miss      <= miss_nxt;
            out_valid <= fwd;
            out_sop   <= fwd && at_first;
            out_eop   <= fwd && at_last;
            pid_valid <= fwd && (pos == POS_W'(2));
            if (fwd) begin
                out_data <= in_data;
            end
            if (fwd && pos == POS_W'(1)) begin
                tei       <= in_data[7];
                pid[12:8] <= in_data[4:0];
            end
            if (fwd && pos == POS_W'(2)) begin
                pid[7:0] <= in_data[7:0];
            end
            if (fwd && at_last && pkt_count != '1) begin
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (lost && sync_loss_count != '1) begin
                sync_loss_count <= sync_loss_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ts_packet_sync.sv
// Randomised bench for ts_packet_sync against a packet-level reference model
// that hunts, verifies and tracks alignment by stepping over whole packets.
module tb_ts_packet_sync;

    localparam int         PKT     = 188;
    localparam int         LOCKN   = 3;
    localparam int         UNLOCKN = 3;
    localparam int         CW      = 3;
    localparam int         MAXC    = (1 << CW) - 1;
    localparam logic [7:0] SYNC    = 8'h47;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_sop;
    logic          out_eop;
    logic          locked;
    logic [12:0]   pid;
    logic          tei;
    logic          pid_valid;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] sync_loss_count;

    ts_packet_sync #(
        .DATA_WIDTH(8), .PKT_LEN(PKT), .SYNC_BYTE(SYNC),
        .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .locked(locked), .pid(pid), .tei(tei), .pid_valid(pid_valid),
        .pkt_count(pkt_count), .sync_loss_count(sync_loss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim[$];
    logic [9:0]  exp_out[$], got_out[$];
    logic [13:0] exp_pid[$], got_pid[$];
    int          exp_pid_at[$], got_pid_at[$];
    bit          lk[];
    int          exp_pkts, exp_losses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled mid-cycle away from the rising edge.
    always @(negedge clk) begin
        if (out_valid) got_out.push_back({out_sop, out_eop, out_data});
        if (pid_valid) begin
            got_pid.push_back({tei, pid});
            got_pid_at.push_back(got_out.size() - 1);
        end
    end

    function automatic logic [7:0] rand_payload();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == SYNC) ? 8'h00 : b;
    endfunction

    function automatic void make_clean(input int npk);
        stim.delete();
        for (int p = 0; p < npk; p++)
            for (int q = 0; q < PKT; q++)
                stim.push_back(q == 0 ? SYNC : rand_payload());
    endfunction

    // Packet-level model: find a candidate sync, test the next LOCKN-1 packet
    // starts, then walk whole packets counting consecutive missing syncs.
    function automatic void build_model(input int n);
        int  i, k, p, miss, fail;
        bit  done, hunting;
        exp_out.delete(); exp_pid.delete(); exp_pid_at.delete();
        lk = new[n];
        exp_pkts = 0; exp_losses = 0;
        i = 0; done = 0;
        while (!done) begin
            k = -1;
            for (int j = i; j < n && k < 0; j++) if (stim[j] == SYNC) k = j;
            if (k < 0) begin
                done = 1;
            end else begin
                fail = -1;
                for (int j = 1; j < LOCKN && fail < 0; j++) begin
                    if (k + PKT * j >= n) fail = n;
                    else if (stim[k + PKT * j] != SYNC) fail = k + PKT * j;
                end
                if (fail == n) begin
                    done = 1;
                end else if (fail >= 0) begin
                    i = fail + 1;
                end else begin
                    p = k + PKT * (LOCKN - 1);
                    miss = 0; hunting = 0;
                    while (!done && !hunting) begin
                        for (int q = 0; q < PKT && p + q < n; q++) begin
                            exp_out.push_back({q == 0, q == PKT - 1, stim[p + q]});
                            lk[p + q] = 1;
                            if (q == 2) begin
                                exp_pid.push_back({stim[p + 1][7], stim[p + 1][4:0], stim[p + 2]});
                                exp_pid_at.push_back(exp_out.size() - 1);
                            end
                            if (q == PKT - 1) exp_pkts = (exp_pkts == MAXC) ? MAXC : exp_pkts + 1;
                        end
                        p += PKT;
                        if (p >= n) begin
                            done = 1;
                        end else if (stim[p] == SYNC) begin
                            miss = 0;
                        end else begin
                            miss++;
                            if (miss == UNLOCKN) begin
                                exp_losses = (exp_losses == MAXC) ? MAXC : exp_losses + 1;
                                i = p + 1;
                                hunting = 1;
                            end
                        end
                    end
                end
            end
        end
    endfunction

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // gap_mode 0: one idle cycle between bytes; 1: random 0..2 idle cycles.
    task automatic run_stream(input bit do_reset, input int gap_mode, input int n, input string tag);
        int gap;
        if (do_reset) apply_reset();
        build_model(n);
        got_out.delete(); got_pid.delete(); got_pid_at.delete();
        for (int i = 0; i < n; i++) begin
            gap = (gap_mode == 0) ? 1 : int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1; in_data = stim[i];
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = 8'($urandom);
            check({tag, "_locked"}, locked, lk[i]);
        end
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_out_count"}, got_out.size(), exp_out.size());
        for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
            check({tag, "_out_byte"}, got_out[i], exp_out[i]);
        check({tag, "_pid_count"}, got_pid.size(), exp_pid.size());
        for (int i = 0; i < exp_pid.size() && i < got_pid.size(); i++) begin
            check({tag, "_pid_tei"}, got_pid[i], exp_pid[i]);
            check({tag, "_pid_pos"}, got_pid_at[i], exp_pid_at[i]);
        end
        check({tag, "_pkt_count"}, pkt_count, exp_pkts);
        check({tag, "_sync_loss"}, sync_loss_count, exp_losses);
    endtask

    function automatic logic [31:0] got_out_at(input int k);
        return (got_out.size() > k) ? 32'(got_out[k]) : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] got_pid_at_idx(input int k);
        return (got_pid.size() > k) ? 32'(got_pid[k]) : 32'hffff_ffff;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        @(posedge clk); #1;
        check("reset_outputs",
              {out_valid, out_sop, out_eop, locked, tei, pid_valid, out_data, pid, pkt_count, sync_loss_count}, 0);

        // Clean stream, alternating valid.
        make_clean(5);
        run_stream(1, 0, stim.size(), "clean");
        check("clean_first_sop", got_out_at(0), {2'b10, SYNC});
        check("clean_pkts_const", pkt_count, 3);
        check("clean_loss_const", sync_loss_count, 0);

        // PID/TEI extraction on known headers.
        make_clean(6);
        stim[2 * PKT + 1] = 8'h41; stim[2 * PKT + 2] = 8'h00;
        stim[3 * PKT + 1] = 8'hC0; stim[3 * PKT + 2] = 8'h11;
        run_stream(1, 1, stim.size(), "pid");
        check("pid_first", got_pid_at_idx(0), {1'b0, 13'h100});
        check("pid_second", got_pid_at_idx(1), {1'b1, 13'h011});

        // One corrupted sync while locked; long enough to saturate pkt_count.
        make_clean(12);
        stim[4 * PKT] = 8'h00;
        run_stream(1, 1, stim.size(), "flywheel");
        check("flywheel_locked", locked, 1);
        check("flywheel_pkts_sat", pkt_count, MAXC);

        // Three consecutive corrupted syncs, then relock.
        make_clean(11);
        stim[4 * PKT] = 8'h00; stim[5 * PKT] = 8'h00; stim[6 * PKT] = 8'h00;
        run_stream(1, 1, stim.size(), "unlock");
        check("unlock_loss_const", sync_loss_count, 1);

        // False sync at offset 5, true alignment at offset 10.
        stim.delete();
        for (int i = 0; i < 1000; i++) stim.push_back(rand_payload());
        stim[5] = SYNC;
        for (int i = 10; i < 1000; i += PKT) stim[i] = SYNC;
        run_stream(1, 1, stim.size(), "false_sync");

        // Reset mid-packet while locked, with a byte presented during reset.
        make_clean(4);
        run_stream(1, 1, 2 * PKT + PKT + 90, "pre_rst");
        rst = 1'b1; in_valid = 1'b1; in_data = SYNC;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_pulses", {out_valid, out_sop, out_eop, pid_valid, locked}, 0);
        check("mid_rst_fields", {out_data, pid, tei}, 0);
        check("mid_rst_counters", {pkt_count, sync_loss_count}, 0);
        make_clean(5);
        run_stream(0, 0, stim.size(), "relock");
        check("relock_pkts_const", pkt_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
